// File: rtl/controlador_partida_pkg.sv
// Shared types and constants for the basketball game sequencer.
package controlador_partida_pkg;

  localparam int unsigned MIN_W = 4;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned SHOT_W = 5;
  localparam int unsigned PER_W = 3;
  localparam int unsigned TOT_W = 10;

  localparam int unsigned SHOT_FULL_DEF = 24;
  localparam int unsigned SHOT_SHORT_DEF = 14;
  localparam int unsigned BUZZ_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_PAUSE      = 3'd2,
    ST_SHOT_VIOL  = 3'd3,
    ST_PERIOD_END = 3'd4,
    ST_GAME_END   = 3'd5
  } estado_t;

  // Remaining period time in seconds, wide enough for 15:59.
  function automatic logic [TOT_W-1:0] tempo_total(input logic [MIN_W-1:0] mm,
                                                   input logic [SEC_W-1:0] ss);
    return TOT_W'(mm) * TOT_W'(60) + TOT_W'(ss);
  endfunction

endpackage

// File: rtl/controlador_partida_detector_borda.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 input change.
module controlador_partida_detector_borda (
  input  logic clock_in,
  input  logic reset_in_n,
  input  logic nivel_i,
  output logic pulso_o
);

  logic nivel_q;
  logic pulso_q;

  always_ff @(posedge clock_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      nivel_q <= nivel_i;
      pulso_q <= nivel_i & ~nivel_q;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/controlador_partida.sv
// Basketball game sequencer: period clock, shot clock, period count and shared buzzer.
module controlador_partida
  import controlador_partida_pkg::*;
#(
  parameter int unsigned PERIOD_MIN  = 10,
  parameter int unsigned NUM_PERIODS = 4,
  parameter int unsigned SHOT_FULL   = SHOT_FULL_DEF,
  parameter int unsigned SHOT_SHORT  = SHOT_SHORT_DEF,
  parameter int unsigned BUZZ_CYCLES = BUZZ_CYCLES_DEF
) (
  input  logic              clock_in,
  input  logic              reset_in_n,
  input  logic              tick_sec,
  input  logic              btn_start,
  input  logic              btn_reload24,
  input  logic              btn_reload14,
  output logic [MIN_W-1:0]  game_min,
  output logic [SEC_W-1:0]  game_sec,
  output logic [SHOT_W-1:0] shot_sec,
  output logic              shot_blank,
  output logic [PER_W-1:0]  period,
  output logic              running,
  output logic              buzzer,
  output logic              game_over
);

  localparam int unsigned BUZZ_W = $clog2(BUZZ_CYCLES + 1);

  logic p_start, p_r24, p_r14;

  controlador_partida_detector_borda u_borda_start (
    .clock_in(clock_in), .reset_in_n(reset_in_n), .nivel_i(btn_start), .pulso_o(p_start));
  controlador_partida_detector_borda u_borda_r24 (
    .clock_in(clock_in), .reset_in_n(reset_in_n), .nivel_i(btn_reload24), .pulso_o(p_r24));
  controlador_partida_detector_borda u_borda_r14 (
    .clock_in(clock_in), .reset_in_n(reset_in_n), .nivel_i(btn_reload14), .pulso_o(p_r14));

  estado_t           state_q, state_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [SHOT_W-1:0] shot_q, shot_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic [BUZZ_W-1:0] bcnt_q, bcnt_d;
  logic              blank_q, blank_d;
  logic              running_q, running_d;
  logic              over_q, over_d;
  logic              buzz_q, buzz_d;
  logic              evento, fim_tempo, violacao, aceita, rl24, rl14;

  always_ff @(posedge clock_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q   <= ST_IDLE;
      min_q     <= MIN_W'(PERIOD_MIN);
      sec_q     <= '0;
      shot_q    <= SHOT_W'(SHOT_FULL);
      period_q  <= PER_W'(1);
      bcnt_q    <= '0;
      blank_q   <= 1'b0;
      running_q <= 1'b0;
      over_q    <= 1'b0;
      buzz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      shot_q    <= shot_d;
      period_q  <= period_d;
      bcnt_q    <= bcnt_d;
      blank_q   <= blank_d;
      running_q <= running_d;
      over_q    <= over_d;
      buzz_q    <= buzz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    shot_d    = shot_q;
    period_d  = period_q;
    evento    = 1'b0;
    fim_tempo = 1'b0;
    violacao  = 1'b0;
    aceita    = (state_q != ST_PERIOD_END) && (state_q != ST_GAME_END);
    rl24      = aceita && p_r24;
    rl14      = aceita && p_r14 && !p_r24;

    case (state_q)
      ST_IDLE: if (p_start) state_d = ST_RUN;
      ST_RUN: begin
        if (tick_sec) begin
          fim_tempo = (min_q == '0) && (sec_q == SEC_W'(1));
          if (sec_q == '0) begin
            sec_d = SEC_W'(59);
            min_d = min_q - MIN_W'(1);
          end else begin
            sec_d = sec_q - SEC_W'(1);
          end
          // Any accepted reload this cycle suppresses the shot decrement.
          if (!rl24 && !rl14 && !blank_q && (shot_q != '0)) begin
            shot_d   = shot_q - SHOT_W'(1);
            violacao = (shot_q == SHOT_W'(1));
          end
        end
        if (fim_tempo) begin
          state_d = (period_q == PER_W'(NUM_PERIODS)) ? ST_GAME_END : ST_PERIOD_END;
          evento  = 1'b1;
        end else if (violacao) begin
          state_d = ST_SHOT_VIOL;
          evento  = 1'b1;
        end else if (p_start) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: if (p_start) state_d = ST_RUN;
      ST_SHOT_VIOL: if (p_r24 || p_r14) state_d = ST_PAUSE;
      ST_PERIOD_END: begin
        if (p_start) begin
          state_d  = ST_IDLE;
          period_d = period_q + PER_W'(1);
          min_d    = MIN_W'(PERIOD_MIN);
          sec_d    = '0;
          shot_d   = SHOT_W'(SHOT_FULL);
        end
      end
      ST_GAME_END: state_d = ST_GAME_END;
      default: state_d = ST_IDLE;
    endcase

    if (rl24) begin
      shot_d = SHOT_W'(SHOT_FULL);
    end else if (rl14 && (shot_q < SHOT_W'(SHOT_SHORT))) begin
      shot_d = SHOT_W'(SHOT_SHORT);
    end

    // Each event restarts the buzz window, so overlapping events never leave a gap.
    if (evento) begin
      bcnt_d = BUZZ_W'(BUZZ_CYCLES);
    end else if (bcnt_q != '0) begin
      bcnt_d = bcnt_q - BUZZ_W'(1);
    end else begin
      bcnt_d = bcnt_q;
    end

    blank_d   = ((state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                (tempo_total(min_d, sec_d) < TOT_W'(shot_d));
    running_d = (state_d == ST_RUN);
    over_d    = (state_d == ST_GAME_END);
    buzz_d    = (bcnt_d != '0);
  end

  assign game_min   = min_q;
  assign game_sec   = sec_q;
  assign shot_sec   = shot_q;
  assign shot_blank = blank_q;
  assign period     = period_q;
  assign running    = running_q;
  assign buzzer     = buzz_q;
  assign game_over  = over_q;

endmodule
